// File: rtl/envo_sched.sv
// envo_sched: grid-access scheduler. Arbitrates the shared cell-grid datapath
// between the evolution engine (generation steps paced by a speed-controlled
// tick), the fill unit (clear / random / pattern) and the cursor write path.
// Exactly one owner at a time, one-hot grants, all outputs registered.
module envo_sched #(
    parameter int unsigned BASE_TICKS = 6_250_000,
    parameter logic [2:0]  SPEED_RST  = 3'd3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mode,
    input  logic        clr,
    input  logic        inc_v,
    input  logic        dec_v,
    input  logic        user_set,
    input  logic        random,
    input  logic        pattern,
    input  logic        gen_done,
    input  logic        fill_done,
    output logic        gen_start,
    output logic        fill_start,
    output logic [1:0]  fill_kind,
    output logic        user_wr,
    output logic        grant_gen,
    output logic        grant_fill,
    output logic        grant_user,
    output logic        busy,
    output logic [2:0]  speed,
    output logic [15:0] gen_count
);

    // Longest tick period is BASE_TICKS*8 cycles (speed 0).
    localparam int unsigned CNT_W = (BASE_TICKS * 8 > 2) ? $clog2(BASE_TICKS * 8) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FILL  = 2'd1,
        S_GEN   = 2'd2,
        S_WRITE = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        FK_CLEAR   = 2'd0,
        FK_RANDOM  = 2'd1,
        FK_PATTERN = 2'd2
    } fill_kind_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t           state_q, state_d;
    fill_kind_t       fill_kind_q, fill_kind_d;
    logic [2:0]       speed_q, speed_d;
    logic [15:0]      gen_count_q, gen_count_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick_pend_q, tick_pend_d;

    // Previous value of each level input, for rising-edge detection.
    logic clr_prev_q, inc_prev_q, dec_prev_q, usr_prev_q, rnd_prev_q, pat_prev_q;

    // Requests latched on a rising edge and held until the FSM services them.
    logic clr_p_q, pat_p_q, rnd_p_q, usr_p_q;
    logic clr_p_d, pat_p_d, rnd_p_d, usr_p_d;

    // Registered outputs.
    logic gen_start_q,  gen_start_d;
    logic fill_start_q, fill_start_d;
    logic user_wr_q,    user_wr_d;
    logic grant_gen_q,  grant_gen_d;
    logic grant_fill_q, grant_fill_d;
    logic grant_user_q, grant_user_d;
    logic busy_q,       busy_d;

    // ------------------------------------------------------------------
    // Edge detection
    // ------------------------------------------------------------------
    logic clr_rise, inc_rise, dec_rise, usr_rise, rnd_rise, pat_rise;

    assign clr_rise = clr      & ~clr_prev_q;
    assign inc_rise = inc_v    & ~inc_prev_q;
    assign dec_rise = dec_v    & ~dec_prev_q;
    assign usr_rise = user_set & ~usr_prev_q;
    assign rnd_rise = random   & ~rnd_prev_q;
    assign pat_rise = pattern  & ~pat_prev_q;

    // Speed level: one step per key press, saturating, simultaneous presses cancel.
    always_comb begin
        speed_d = speed_q;
        if (inc_rise && !dec_rise && speed_q != 3'd7) begin
            speed_d = speed_q + 3'd1;
        end else if (dec_rise && !inc_rise && speed_q != 3'd0) begin
            speed_d = speed_q - 3'd1;
        end
    end

    // ------------------------------------------------------------------
    // Tick generator
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] tick_last;
    logic             tick_fire;

    // Last count of the current period; >= covers a speed-up that shortened the period
    // below the running count.
    assign tick_last = CNT_W'(BASE_TICKS * (32'd8 - {29'd0, speed_q}) - 32'd1);
    assign tick_fire = mode && (cnt_q >= tick_last);

    // Tick counter: runs only in evolve mode, wraps at the end of each period.
    always_comb begin
        cnt_d = '0;
        if (mode && !tick_fire) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Scheduler FSM: next state, service flags and registered outputs
    // ------------------------------------------------------------------
    logic take_clr, take_pat, take_rnd, take_usr, take_tick;

    // Pick the next owner in IDLE by fixed priority and track completion of the active op.
    always_comb begin
        // NOTE: every signal assigned here gets a default first so no path leaves one
        // unassigned; that is what keeps this block from inferring latches.
        state_d     = state_q;
        fill_kind_d = fill_kind_q;
        gen_count_d = gen_count_q;
        take_clr    = 1'b0;
        take_pat    = 1'b0;
        take_rnd    = 1'b0;
        take_usr    = 1'b0;
        take_tick   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (clr_p_q) begin
                    state_d     = S_FILL;
                    fill_kind_d = FK_CLEAR;
                    take_clr    = 1'b1;
                end else if (pat_p_q) begin
                    state_d     = S_FILL;
                    fill_kind_d = FK_PATTERN;
                    take_pat    = 1'b1;
                end else if (rnd_p_q) begin
                    state_d     = S_FILL;
                    fill_kind_d = FK_RANDOM;
                    take_rnd    = 1'b1;
                end else if (usr_p_q) begin
                    state_d  = S_WRITE;
                    take_usr = 1'b1;
                end else if (tick_pend_q) begin
                    state_d   = S_GEN;
                    take_tick = 1'b1;
                end
            end
            S_FILL: begin
                if (fill_done) begin
                    state_d = S_IDLE;
                    if (fill_kind_q == FK_CLEAR) begin
                        gen_count_d = 16'd0;
                    end
                end
            end
            S_GEN: begin
                if (gen_done) begin
                    state_d     = S_IDLE;
                    gen_count_d = gen_count_q + 16'd1;
                end
            end
            S_WRITE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Pending request flags: a fresh rise wins over a same-cycle service.
    always_comb begin
        clr_p_d     = clr_rise | (clr_p_q & ~take_clr);
        pat_p_d     = pat_rise | (pat_p_q & ~take_pat);
        rnd_p_d     = rnd_rise | (rnd_p_q & ~take_rnd);
        usr_p_d     = (usr_rise & ~mode) | (usr_p_q & ~take_usr);
        tick_pend_d = mode & (tick_fire | (tick_pend_q & ~take_tick));
    end

    // Output decode from the next state so grants/strobes line up with the state register.
    always_comb begin
        grant_gen_d  = (state_d == S_GEN);
        grant_fill_d = (state_d == S_FILL);
        grant_user_d = (state_d == S_WRITE);
        user_wr_d    = (state_d == S_WRITE);
        busy_d       = (state_d != S_IDLE);
        gen_start_d  = (state_d == S_GEN)  && (state_q != S_GEN);
        fill_start_d = (state_d == S_FILL) && (state_q != S_FILL);
    end

    // State, counters, flags and output registers.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: the reset branch restores every register, so a reset in the middle of an
        // operation abandons it cleanly; nothing here is a memory that could skip reset.
        if (!rst) begin
            state_q      <= S_IDLE;
            fill_kind_q  <= FK_CLEAR;
            speed_q      <= SPEED_RST;
            gen_count_q  <= 16'd0;
            cnt_q        <= '0;
            tick_pend_q  <= 1'b0;
            clr_prev_q   <= 1'b0;
            inc_prev_q   <= 1'b0;
            dec_prev_q   <= 1'b0;
            usr_prev_q   <= 1'b0;
            rnd_prev_q   <= 1'b0;
            pat_prev_q   <= 1'b0;
            clr_p_q      <= 1'b0;
            pat_p_q      <= 1'b0;
            rnd_p_q      <= 1'b0;
            usr_p_q      <= 1'b0;
            gen_start_q  <= 1'b0;
            fill_start_q <= 1'b0;
            user_wr_q    <= 1'b0;
            grant_gen_q  <= 1'b0;
            grant_fill_q <= 1'b0;
            grant_user_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values,
            // independent of statement order.
            state_q      <= state_d;
            fill_kind_q  <= fill_kind_d;
            speed_q      <= speed_d;
            gen_count_q  <= gen_count_d;
            cnt_q        <= cnt_d;
            tick_pend_q  <= tick_pend_d;
            clr_prev_q   <= clr;
            inc_prev_q   <= inc_v;
            dec_prev_q   <= dec_v;
            usr_prev_q   <= user_set;
            rnd_prev_q   <= random;
            pat_prev_q   <= pattern;
            clr_p_q      <= clr_p_d;
            pat_p_q      <= pat_p_d;
            rnd_p_q      <= rnd_p_d;
            usr_p_q      <= usr_p_d;
            gen_start_q  <= gen_start_d;
            fill_start_q <= fill_start_d;
            user_wr_q    <= user_wr_d;
            grant_gen_q  <= grant_gen_d;
            grant_fill_q <= grant_fill_d;
            grant_user_q <= grant_user_d;
            busy_q       <= busy_d;
        end
    end

    assign gen_start  = gen_start_q;
    assign fill_start = fill_start_q;
    assign fill_kind  = fill_kind_q;
    assign user_wr    = user_wr_q;
    assign grant_gen  = grant_gen_q;
    assign grant_fill = grant_fill_q;
    assign grant_user = grant_user_q;
    assign busy       = busy_q;
    assign speed      = speed_q;
    assign gen_count  = gen_count_q;

endmodule
